// File: rtl/seq_mult_32bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_32bit_pkg
// Description : Shared types and constants for the sequential 32x32 multiplier
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mult_32bit_pkg;

   localparam int c_op_width   = 32;
   localparam int c_prod_width = 2 * c_op_width;

   // Index of the final shift-and-add step (32 steps, counted from zero)
   localparam logic [5:0] c_last_step = 6'd31;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mult_32bit_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_32bit_if
// Description : Request / result handshake bundle for the sequential multiplier
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_mult_32bit_if;
   import seq_mult_32bit_pkg::*;

   logic                    start_valid;
   logic                    start_ready;
   logic [c_op_width-1:0]   a;
   logic [c_op_width-1:0]   b;
   logic                    busy;
   logic                    done;
   logic [c_prod_width-1:0] product;

   // Requester side
   modport master (
      output start_valid, a, b,
      input  start_ready, busy, done, product
   );

   // Multiplier side
   modport slave (
      input  start_valid, a, b,
      output start_ready, busy, done, product
   );

endinterface
`default_nettype wire

// File: rtl/cla_adder_32bit.sv
`default_nettype none
// ============================================================================
// Module      : cla_adder_32bit
// Description : 32-bit two-level carry-lookahead adder (8 groups of 4 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module cla_adder_32bit (
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        C0,
   output logic [31:0] S,
   output logic        C32,
   output logic        Pg,
   output logic        Gg,
   output logic        overflow
);

   logic [31:0] w_g;
   logic [31:0] w_p;
   logic [31:0] w_bc;      // carry into each bit
   logic [7:0]  w_grp_g;
   logic [7:0]  w_grp_p;
   logic [8:0]  w_gc;      // carry into each 4-bit group; [8] is the carry out

   assign w_g = A & B;
   assign w_p = A ^ B;

   // First level: bit carries inside each group from that group's carry-in
   for (genvar k = 0; k < 8; k++) begin : g_group
      logic [3:0] w_gk;
      logic [3:0] w_pk;
      logic       w_ci;

      assign w_gk = w_g[4*k +: 4];
      assign w_pk = w_p[4*k +: 4];
      assign w_ci = w_gc[k];

      assign w_bc[4*k]   = w_ci;
      assign w_bc[4*k+1] = w_gk[0] | (w_pk[0] & w_ci);
      assign w_bc[4*k+2] = w_gk[1] | (w_pk[1] & w_gk[0]) | (w_pk[1] & w_pk[0] & w_ci);
      assign w_bc[4*k+3] = w_gk[2] | (w_pk[2] & w_gk[1]) | (w_pk[2] & w_pk[1] & w_gk[0])
                         | (w_pk[2] & w_pk[1] & w_pk[0] & w_ci);

      assign w_grp_g[k] = w_gk[3] | (w_pk[3] & w_gk[2]) | (w_pk[3] & w_pk[2] & w_gk[1])
                        | (w_pk[3] & w_pk[2] & w_pk[1] & w_gk[0]);
      assign w_grp_p[k] = &w_pk;
   end

   // Second level: group carries plus whole-word propagate/generate
   always_comb begin : p_group_lookahead
      logic w_carry;
      logic w_gen;
      logic w_prop;
      w_carry = C0;
      w_gen   = 1'b0;
      w_prop  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         w_gc[k] = w_carry;
         w_carry = w_grp_g[k] | (w_grp_p[k] & w_carry);
         w_gen   = w_grp_g[k] | (w_grp_p[k] & w_gen);
         w_prop  = w_prop & w_grp_p[k];
      end
      w_gc[8] = w_carry;
      Gg      = w_gen;
      Pg      = w_prop;
   end

   assign S        = w_p ^ w_bc;
   assign C32      = w_gc[8];
   assign overflow = w_bc[31] ^ w_gc[8];

endmodule
`default_nettype wire

// File: rtl/seq_mult_32bit.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_32bit
// Description : Unsigned 32x32->64 shift-and-add multiplier, one step per
//               cycle through a 32-bit CLA adder; optional zero-operand bypass
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_32bit
   import seq_mult_32bit_pkg::*;
#(
   parameter int WIDTH      = 32,    // adder is fixed at 32 bits; no other value works
   parameter bit EARLY_ZERO = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   seq_mult_32bit_if.slave bus
);

   state_t               r_state;
   state_t               w_next;
   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic [5:0]           r_cnt;
   logic [2*WIDTH-1:0]   r_product;

   logic [WIDTH-1:0]     w_add_b;
   logic [WIDTH-1:0]     w_sum;
   logic                 w_c32;
   logic                 w_pg;
   logic                 w_gg;
   logic                 w_ovf;
   logic                 w_unused;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_zero;
   logic                 w_last;

   assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_accept = bus.start_valid & w_ready;
   assign w_zero   = EARLY_ZERO && ((bus.a == '0) || (bus.b == '0));
   assign w_last   = (r_state == S_RUN) && (r_cnt == c_last_step);

   // Add the multiplicand only when the current multiplier bit is set
   assign w_add_b = r_lo[0] ? r_mcand : '0;

   cla_adder_32bit u_adder (
      .A        (r_hi),
      .B        (w_add_b),
      .C0       (1'b0),
      .S        (w_sum),
      .C32      (w_c32),
      .Pg       (w_pg),
      .Gg       (w_gg),
      .overflow (w_ovf)
   );

   // Group outputs of the adder are not needed here
   assign w_unused = w_pg ^ w_gg ^ w_ovf;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic: IDLE and DONE both accept; DONE falls back to IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) w_next = w_zero ? S_DONE : S_RUN;
            else          w_next = S_IDLE;
         end
         S_RUN: begin
            if (w_last) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: load on accept, otherwise one shift-and-add step per RUN cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand   <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else if (w_accept) begin
         r_mcand <= bus.a;
         r_hi    <= '0;
         r_lo    <= bus.b;
         r_cnt   <= '0;
         if (w_zero) r_product <= '0;
      end else if (r_state == S_RUN) begin
         // Carry out of the adder becomes the new top bit, so nothing is lost
         r_hi  <= {w_c32, w_sum[WIDTH-1:1]};
         r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
         r_cnt <= r_cnt + 6'd1;
         if (w_last) r_product <= {w_c32, w_sum, r_lo[WIDTH-1:1]};
      end
   end

   assign bus.start_ready = w_ready;
   assign bus.busy        = (r_state == S_RUN);
   assign bus.done        = (r_state == S_DONE);
   assign bus.product     = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_32bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult_32bit
// Description : Self-checking bench for seq_mult_32bit (early-zero on and off)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_mult_32bit;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   seq_mult_32bit_if if0 ();
   seq_mult_32bit_if if1 ();

   seq_mult_32bit #(.WIDTH(32), .EARLY_ZERO(1'b1)) dut_ez (
      .clk (clk),
      .rst (rst),
      .bus (if0.slave)
   );

   seq_mult_32bit #(.WIDTH(32), .EARLY_ZERO(1'b0)) dut_fl (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   // ---------------- helpers ----------------
   function automatic logic get_done(int d);
      return (d == 0) ? if0.done : if1.done;
   endfunction
   function automatic logic get_busy(int d);
      return (d == 0) ? if0.busy : if1.busy;
   endfunction
   function automatic logic get_ready(int d);
      return (d == 0) ? if0.start_ready : if1.start_ready;
   endfunction
   function automatic logic [63:0] get_prod(int d);
      return (d == 0) ? if0.product : if1.product;
   endfunction

   task automatic drive(int d, logic v, logic [31:0] x, logic [31:0] y);
      if (d == 0) begin
         if0.start_valid = v; if0.a = x; if0.b = y;
      end else begin
         if1.start_valid = v; if1.a = x; if1.b = y;
      end
   endtask

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A request is accepted whenever the unit is not mid-multiply; the product
   // a*b appears 32 edges after acceptance, or immediately for a zero operand
   // on the early-zero instance (index 0).
   bit          m_on = 1'b0;
   bit          m_pend [2];
   int          m_due  [2];
   logic [63:0] m_val  [2];
   logic [63:0] m_prod [2];
   bit          m_done [2];

   always @(posedge clk) begin : p_model
      logic        sv;
      logic [31:0] xa;
      logic [31:0] xb;
      cyc = cyc + 1;
      for (int d = 0; d < 2; d++) begin
         sv = (d == 0) ? if0.start_valid : if1.start_valid;
         xa = (d == 0) ? if0.a : if1.a;
         xb = (d == 0) ? if0.b : if1.b;
         if (rst) begin
            m_pend[d] = 1'b0;
            m_done[d] = 1'b0;
            m_prod[d] = 64'd0;
         end else begin
            m_done[d] = 1'b0;
            if (m_pend[d] && cyc == m_due[d]) begin
               m_pend[d] = 1'b0;
               m_done[d] = 1'b1;
               m_prod[d] = m_val[d];
            end else if (sv && !m_pend[d]) begin
               m_val[d] = {32'd0, xa} * {32'd0, xb};
               if (d == 0 && (xa == 32'd0 || xb == 32'd0)) begin
                  m_done[d] = 1'b1;
                  m_prod[d] = m_val[d];
               end else begin
                  m_pend[d] = 1'b1;
                  m_due[d]  = cyc + 32;
               end
            end
         end
      end
      if (rst) m_on = 1'b1;
   end

   // Cycle-by-cycle comparison against the model, on the falling edge
   always @(negedge clk) begin
      if (m_on) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("model busy[%0d]", d),  {63'd0, get_busy(d)},  {63'd0, m_pend[d]});
            chk($sformatf("model ready[%0d]", d), {63'd0, get_ready(d)}, {63'd0, !m_pend[d]});
            chk($sformatf("model done[%0d]", d),  {63'd0, get_done(d)},  {63'd0, m_done[d]});
            chk($sformatf("model product[%0d]", d), get_prod(d), m_prod[d]);
         end
      end
   end

   // ---------------- directed transactions ----------------
   // Issue one request, optionally poke new operands at RUN cycle 'poke',
   // then check latency, busy length and product against literals.
   task automatic run_op(int d, logic [31:0] x, logic [31:0] y, logic [63:0] ep,
                         int elat, int poke, string nm);
      int t0;
      int nb;
      int k;
      bit seen;
      @(negedge clk);
      drive(d, 1'b1, x, y);
      k = 0;
      while (!get_ready(d) && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk({nm, " ready"}, {63'd0, get_ready(d)}, 64'd1);
      @(posedge clk);
      #1 t0 = cyc;
      @(negedge clk);
      nb = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (get_done(d)) begin
            seen = 1'b1;
         end else begin
            if (get_busy(d)) nb++;
            if (poke > 0 && nb == poke) begin
               drive(d, 1'b1, 32'd2, 32'd2);
               chk({nm, " ready mid-run"}, {63'd0, get_ready(d)}, 64'd0);
            end else begin
               drive(d, 1'b0, 32'd0, 32'd0);
            end
            @(negedge clk);
         end
      end
      drive(d, 1'b0, 32'd0, 32'd0);
      chk({nm, " done seen"}, {63'd0, seen}, 64'd1);
      chk({nm, " latency"}, 64'(cyc - t0), 64'(elat));
      chk({nm, " busy cycles"}, 64'(nb), 64'(elat));
      chk({nm, " product"}, get_prod(d), ep);
   endtask

   // From the current falling edge, wait (bounded) for done
   task automatic wait_done(int d, output int t, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (get_done(d)) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      t = cyc;
   endtask

   initial begin
      int t0;
      int t1;
      int t2;
      int t3;
      bit seen;

      // Reset with a request pending on the early-zero unit: reset wins
      rst = 1'b1;
      drive(0, 1'b1, 32'd3, 32'd5);
      drive(1, 1'b0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      chk("reset busy",    {63'd0, if0.busy},        64'd0);
      chk("reset done",    {63'd0, if0.done},        64'd0);
      chk("reset ready",   {63'd0, if0.start_ready}, 64'd1);
      chk("reset product", if0.product,              64'd0);
      rst = 1'b0;
      drive(0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      chk("no accept under reset", {63'd0, if0.busy}, 64'd0);

      // Basic, full-carry, early-zero and full-latency zero cases
      run_op(0, 32'd3, 32'd5, 64'd15, 32, 0, "3x5");
      run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32, 0, "max x max");
      run_op(0, 32'd0, 32'h1234, 64'd0, 0, 0, "early zero a");
      run_op(0, 32'd5, 32'd0, 64'd0, 0, 0, "early zero b");
      run_op(1, 32'd3, 32'd5, 64'd15, 32, 0, "3x5 no-skip");
      run_op(1, 32'd0, 32'h1234, 64'd0, 32, 0, "zero no-skip");

      // Back-to-back requests held on start_valid
      @(negedge clk);
      drive(0, 1'b1, 32'd7, 32'd9);
      chk("b2b ready idle", {63'd0, if0.start_ready}, 64'd1);
      @(posedge clk);
      #1 t0 = cyc;
      @(negedge clk);
      drive(0, 1'b1, 32'h8000_0000, 32'd2);
      wait_done(0, t1, seen);
      chk("b2b first done",    {63'd0, seen}, 64'd1);
      chk("b2b first latency", 64'(t1 - t0), 64'd32);
      chk("b2b first product", if0.product, 64'd63);
      @(posedge clk);
      #1 t2 = cyc;
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0);
      chk("b2b no bubble", {63'd0, if0.busy}, 64'd1);
      wait_done(0, t3, seen);
      chk("b2b second done",    {63'd0, seen}, 64'd1);
      chk("b2b done spacing",   64'(t3 - t1), 64'd33);
      chk("b2b second product", if0.product, 64'h1_0000_0000);

      // New operands pulsed mid-run are ignored
      run_op(0, 32'd1000, 32'd1000, 64'd1000000, 32, 5, "mid-run poke");

      // Reset at RUN cycle 10 aborts the multiply
      @(negedge clk);
      drive(0, 1'b1, 32'd1000, 32'd1000);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 32'd0, 32'd0);
      repeat (9) @(negedge clk);
      chk("abort busy before reset", {63'd0, if0.busy}, 64'd1);
      rst = 1'b1;
      drive(0, 1'b1, 32'd6, 32'd7);
      @(negedge clk);
      chk("abort busy",    {63'd0, if0.busy},        64'd0);
      chk("abort done",    {63'd0, if0.done},        64'd0);
      chk("abort ready",   {63'd0, if0.start_ready}, 64'd1);
      chk("abort product", if0.product,              64'd0);
      rst = 1'b0;
      drive(0, 1'b0, 32'd0, 32'd0);
      run_op(0, 32'd6, 32'd7, 64'd42, 32, 0, "6x7 after abort");

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Hard stop in case a wait somewhere never resolves
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
